// File: rtl/packet_deframer_if.sv
// Bus bundle for packet_deframer: control handshake, input-memory read port,
// output-memory write port and status flags.
interface packet_deframer_if;
    logic        start;
    logic [13:0] addr_in;
    logic [13:0] addr_out;
    logic [13:0] inmem_addr;
    logic [31:0] inmem_data_i;
    logic [13:0] outmem_addr;
    logic [31:0] outmem_data_o;
    logic        outmem_we;
    logic        busy;
    logic        irq;
    logic        crc_err;
    logic        hdr_err;
    logic [4:0]  byte_cnt_o;

    modport master (
        output start, addr_in, addr_out, inmem_data_i,
        input  inmem_addr, outmem_addr, outmem_data_o, outmem_we,
               busy, irq, crc_err, hdr_err, byte_cnt_o
    );

    modport slave (
        input  start, addr_in, addr_out, inmem_data_i,
        output inmem_addr, outmem_addr, outmem_data_o, outmem_we,
               busy, irq, crc_err, hdr_err, byte_cnt_o
    );
endinterface

// File: rtl/packet_deframer.sv
// Parses one framed packet from a byte-wide input memory, copies the payload to
// an output memory and checks its CRC-8 (poly 0x07, init 0x00, MSB first).
module packet_deframer #(
    parameter logic [3:0] SOF_MARK = 4'hC
) (
    input logic              clk,
    input logic              reset,
    packet_deframer_if.slave bus
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RD_HDR0 = 3'd1;
    localparam logic [2:0] S_RD_HDR1 = 3'd2;
    localparam logic [2:0] S_PAYLOAD = 3'd3;
    localparam logic [2:0] S_RD_CRC  = 3'd4;
    localparam logic [2:0] S_CHK     = 3'd5;
    localparam logic [2:0] S_DONE    = 3'd6;

    logic [2:0]  r_state;
    logic [13:0] r_in_base;
    logic [13:0] r_out_base;
    logic [3:0]  r_n;
    logic [4:0]  r_idx;
    logic [4:0]  r_wcnt;
    logic [7:0]  r_crc;
    logic        r_crc_err;
    logic        r_hdr_err;
    logic [4:0]  r_byte_cnt;

    logic [7:0]  w_byte;
    logic        w_we;
    logic        w_unused_hi;

    function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] d);
        logic [7:0] c;
        c = crc ^ d;
        for (int k = 0; k < 8; k++)
            c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        return c;
    endfunction

    assign w_byte      = bus.inmem_data_i[7:0];
    assign w_unused_hi = ^bus.inmem_data_i[31:8];
    // A payload byte arrives one cycle after its read: every PAYLOAD cycle but
    // the first, plus RD_CRC which carries the last byte.
    assign w_we = ((r_state == S_PAYLOAD) && (r_idx != 5'd0)) || (r_state == S_RD_CRC);

    // NOTE: all state uses non-blocking assignments so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_in_base  <= 14'd0;
            r_out_base <= 14'd0;
            r_n        <= 4'd0;
            r_idx      <= 5'd0;
            r_wcnt     <= 5'd0;
            r_crc      <= 8'd0;
            r_crc_err  <= 1'b0;
            r_hdr_err  <= 1'b0;
            r_byte_cnt <= 5'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_in_base  <= bus.addr_in;
                        r_out_base <= bus.addr_out;
                        r_crc_err  <= 1'b0;
                        r_hdr_err  <= 1'b0;
                        r_crc      <= 8'd0;
                        r_idx      <= 5'd0;
                        r_wcnt     <= 5'd0;
                        r_state    <= S_RD_HDR0;
                    end
                end
                S_RD_HDR0: r_state <= S_RD_HDR1;
                S_RD_HDR1: begin
                    if (w_byte[7:4] != SOF_MARK) begin
                        r_hdr_err  <= 1'b1;
                        r_byte_cnt <= 5'd0;
                        r_state    <= S_DONE;
                    end else begin
                        r_n        <= w_byte[3:0];
                        r_byte_cnt <= {1'b0, w_byte[3:0]} + 5'd1;
                        r_state    <= S_PAYLOAD;
                    end
                end
                S_PAYLOAD: begin
                    r_idx <= r_idx + 5'd1;
                    if (r_idx == {1'b0, r_n})
                        r_state <= S_RD_CRC;
                end
                S_RD_CRC: r_state <= S_CHK;
                S_CHK: begin
                    if (w_byte != r_crc)
                        r_crc_err <= 1'b1;
                    r_state <= S_DONE;
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase

            if (w_we) begin
                r_crc  <= crc8_byte(r_crc, w_byte);
                r_wcnt <= r_wcnt + 5'd1;
            end
        end
    end

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        bus.inmem_addr    = 14'd0;
        bus.outmem_addr   = 14'd0;
        bus.outmem_data_o = 32'd0;
        case (r_state)
            S_RD_HDR0: bus.inmem_addr = r_in_base;
            S_RD_HDR1: bus.inmem_addr = r_in_base + 14'd1;
            S_PAYLOAD: bus.inmem_addr = r_in_base + 14'd2 + {9'd0, r_idx};
            S_RD_CRC:  bus.inmem_addr = r_in_base + 14'd3 + {10'd0, r_n};
            default:   bus.inmem_addr = 14'd0;
        endcase
        if (w_we) begin
            bus.outmem_addr   = r_out_base + {9'd0, r_wcnt};
            bus.outmem_data_o = {24'h0, w_byte};
        end
    end

    assign bus.outmem_we  = w_we;
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.irq        = (r_state == S_DONE);
    assign bus.crc_err    = r_crc_err;
    assign bus.hdr_err    = r_hdr_err;
    assign bus.byte_cnt_o = r_byte_cnt;

endmodule

// File: tb/tb_packet_deframer.sv
// Directed bench for packet_deframer: synchronous-read input memory model,
// write logger and per-scenario tasks with hand-computed expectations.
module tb_packet_deframer;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    packet_deframer_if bus ();

    packet_deframer #(.SOF_MARK(4'hC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [7:0] mem [0:16383];
    logic [7:0] r_rd = 8'h00;
    always @(posedge clk) r_rd <= mem[bus.inmem_addr];
    assign bus.inmem_data_i = {24'h0, r_rd};

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [13:0] wr_addr [$];
    logic [31:0] wr_data [$];
    int          wr_cyc  [$];
    always @(negedge clk) begin
        if (bus.outmem_we === 1'b1) begin
            wr_addr.push_back(bus.outmem_addr);
            wr_data.push_back(bus.outmem_data_o);
            wr_cyc.push_back(cyc);
        end
    end

    logic [7:0] pl [0:15];

    function automatic logic [7:0] crc8_ser(input int n);
        logic [7:0] c;
        logic fb;
        c = 8'h00;
        for (int i = 0; i < n; i++)
            for (int b = 7; b >= 0; b--) begin
                fb = c[7] ^ pl[i][b];
                c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
            end
        return c;
    endfunction

    task automatic put(input logic [13:0] a, input logic [7:0] b);
        mem[a] = b;
    endtask

    // Launches a packet, returns the edge index (start edge = 0) at which irq
    // is sampled high, then checks irq drops and busy clears on the next cycle.
    task automatic run_packet(input logic [13:0] a_in, input logic [13:0] a_out,
                              input bit now, input bit poke, output int lat);
        bit done;
        wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
        if (!now) @(negedge clk);
        bus.addr_in = a_in; bus.addr_out = a_out; bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        lat = 0; done = 1'b0;
        while (!done && lat < 200) begin
            @(negedge clk);
            lat++;
            if (bus.irq === 1'b1) done = 1'b1;
            else if (poke && lat == 3) begin bus.start = 1'b1; bus.addr_in = 14'h0123; end
            else bus.start = 1'b0;
        end
        bus.start = 1'b0;
        checks++;
        if (!done) begin failures++; $display("FAIL irq_timeout: got no irq within %0d cycles, expected irq", lat); end
        @(negedge clk);
        checks++;
        if (bus.irq !== 1'b0 || bus.busy !== 1'b0) begin
            failures++; $display("FAIL irq_pulse: got irq=%b busy=%b, expected 0 0", bus.irq, bus.busy);
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({bus.busy, bus.irq, bus.outmem_we, bus.crc_err, bus.hdr_err} !== 5'b0 ||
            bus.byte_cnt_o !== 5'd0 || bus.inmem_addr !== 14'd0 ||
            bus.outmem_addr !== 14'd0 || bus.outmem_data_o !== 32'd0) begin
            failures++; $display("FAIL reset_state: got busy=%b irq=%b we=%b cnt=%0d ia=%h oa=%h, expected all 0",
                                 bus.busy, bus.irq, bus.outmem_we, bus.byte_cnt_o, bus.inmem_addr, bus.outmem_addr);
        end
        repeat (3) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_single();
        int lat;
        put(14'h100, 8'hC0); put(14'h101, 8'h00); put(14'h102, 8'h01); put(14'h103, 8'h07);
        run_packet(14'h100, 14'h200, 1'b0, 1'b0, lat);
        checks++; if (lat !== 6) begin failures++; $display("FAIL single_lat: got %0d, expected 6", lat); end
        checks++;
        if (wr_addr.size() !== 1) begin failures++; $display("FAIL single_nwr: got %0d, expected 1", wr_addr.size()); end
        else if (wr_addr[0] !== 14'h200 || wr_data[0] !== 32'h1) begin
            failures++; $display("FAIL single_wr: got %h@%h, expected 00000001@0200", wr_data[0], wr_addr[0]);
        end
        checks++;
        if (bus.crc_err !== 1'b0 || bus.hdr_err !== 1'b0 || bus.byte_cnt_o !== 5'd1) begin
            failures++; $display("FAIL single_flags: got crc=%b hdr=%b cnt=%0d, expected 0 0 1", bus.crc_err, bus.hdr_err, bus.byte_cnt_o);
        end
    endtask

    task automatic test_two(input logic [7:0] crc_byte, input bit exp_err);
        int lat;
        put(14'h300, 8'hC1); put(14'h301, 8'h55); put(14'h302, 8'h01); put(14'h303, 8'h02);
        put(14'h304, crc_byte);
        run_packet(14'h300, 14'h400, 1'b0, 1'b0, lat);
        checks++; if (lat !== 7) begin failures++; $display("FAIL two_lat: got %0d, expected 7", lat); end
        checks++;
        if (wr_addr.size() !== 2) begin failures++; $display("FAIL two_nwr: got %0d, expected 2", wr_addr.size()); end
        else if (wr_addr[0] !== 14'h400 || wr_data[0] !== 32'h1 || wr_addr[1] !== 14'h401 ||
                 wr_data[1] !== 32'h2 || wr_cyc[1] !== wr_cyc[0] + 1) begin
            failures++; $display("FAIL two_wr: got %h@%h,%h@%h gap=%0d, expected 1@400,2@401 gap=1",
                                 wr_data[0], wr_addr[0], wr_data[1], wr_addr[1], wr_cyc[1] - wr_cyc[0]);
        end
        checks++;
        if (bus.crc_err !== exp_err || bus.byte_cnt_o !== 5'd2) begin
            failures++; $display("FAIL two_flags: got crc=%b cnt=%0d, expected %b 2", bus.crc_err, bus.byte_cnt_o, exp_err);
        end
    endtask

    task automatic test_crc_err();
        test_two(8'h1A, 1'b1);
        repeat (5) @(negedge clk);
        checks++;
        if (bus.crc_err !== 1'b1 || bus.byte_cnt_o !== 5'd2) begin
            failures++; $display("FAIL crc_hold: got crc=%b cnt=%0d, expected 1 2", bus.crc_err, bus.byte_cnt_o);
        end
    endtask

    task automatic test_hdr_err();
        int lat;
        put(14'h500, 8'hA3); put(14'h501, 8'h00); put(14'h502, 8'h11);
        run_packet(14'h500, 14'h580, 1'b0, 1'b0, lat);
        checks++; if (lat !== 3) begin failures++; $display("FAIL hdr_lat: got %0d, expected 3", lat); end
        checks++;
        if (wr_addr.size() !== 0) begin failures++; $display("FAIL hdr_nwr: got %0d, expected 0", wr_addr.size()); end
        checks++;
        if (bus.hdr_err !== 1'b1 || bus.crc_err !== 1'b0 || bus.byte_cnt_o !== 5'd0) begin
            failures++; $display("FAIL hdr_flags: got hdr=%b crc=%b cnt=%0d, expected 1 0 0", bus.hdr_err, bus.crc_err, bus.byte_cnt_o);
        end
    endtask

    task automatic test_wrap();
        int lat;
        bit bad;
        put(14'h3FFE, 8'hCF); put(14'h3FFF, 8'h42);
        for (int i = 0; i < 16; i++) begin pl[i] = 8'(i * 37 + 5); put(14'(i), pl[i]); end
        put(14'h0010, crc8_ser(16));
        run_packet(14'h3FFE, 14'h3FF8, 1'b0, 1'b0, lat);
        checks++; if (lat !== 21) begin failures++; $display("FAIL wrap_lat: got %0d, expected 21", lat); end
        checks++;
        if (wr_addr.size() !== 16) begin failures++; $display("FAIL wrap_nwr: got %0d, expected 16", wr_addr.size()); end
        else begin
            bad = 1'b0;
            for (int i = 0; i < 16; i++)
                if (wr_addr[i] !== 14'(14'h3FF8 + i) || wr_data[i] !== {24'h0, pl[i]}) bad = 1'b1;
            if (bad) begin
                failures++; $display("FAIL wrap_wr: got first %h@%h last %h@%h, expected %h@3ff8 %h@0007",
                                     wr_data[0], wr_addr[0], wr_data[15], wr_addr[15], pl[0], pl[15]);
            end
        end
        checks++;
        if (bus.crc_err !== 1'b0 || bus.hdr_err !== 1'b0 || bus.byte_cnt_o !== 5'd16) begin
            failures++; $display("FAIL wrap_flags: got crc=%b hdr=%b cnt=%0d, expected 0 0 16", bus.crc_err, bus.hdr_err, bus.byte_cnt_o);
        end
    endtask

    task automatic test_busy_start();
        int lat;
        put(14'h0123, 8'h00);
        test_two(8'h1B, 1'b0);
        put(14'h300, 8'hC1);
        run_packet(14'h300, 14'h400, 1'b0, 1'b1, lat);
        repeat (4) @(negedge clk);
        checks++;
        if (lat !== 7 || wr_addr.size() !== 2 || bus.busy !== 1'b0 || bus.hdr_err !== 1'b0) begin
            failures++; $display("FAIL busy_start: got lat=%0d nwr=%0d busy=%b hdr=%b, expected 7 2 0 0",
                                 lat, wr_addr.size(), bus.busy, bus.hdr_err);
        end
    endtask

    task automatic test_reset_abort();
        int lat;
        int guard;
        put(14'h600, 8'hCF); put(14'h601, 8'h00);
        for (int i = 0; i < 17; i++) put(14'(14'h602 + i), 8'(i + 1));
        wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
        @(negedge clk);
        bus.addr_in = 14'h600; bus.addr_out = 14'h700; bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        guard = 0;
        while (wr_addr.size() < 2 && guard < 50) begin @(negedge clk); guard++; end
        checks++;
        if (wr_addr.size() < 2) begin failures++; $display("FAIL abort_writes: got %0d writes, expected >=2", wr_addr.size()); end
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({bus.busy, bus.irq, bus.outmem_we, bus.crc_err, bus.hdr_err} !== 5'b0 ||
            bus.byte_cnt_o !== 5'd0 || bus.inmem_addr !== 14'd0 ||
            bus.outmem_addr !== 14'd0 || bus.outmem_data_o !== 32'd0) begin
            failures++; $display("FAIL abort_state: got busy=%b irq=%b we=%b cnt=%0d ia=%h oa=%h, expected all 0",
                                 bus.busy, bus.irq, bus.outmem_we, bus.byte_cnt_o, bus.inmem_addr, bus.outmem_addr);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (bus.irq !== 1'b0) begin failures++; $display("FAIL abort_irq: got %b, expected 0", bus.irq); end
        end
        reset = 1'b1;
        run_packet(14'h100, 14'h200, 1'b1, 1'b0, lat);
        checks++;
        if (lat !== 6 || wr_addr.size() !== 1 || bus.byte_cnt_o !== 5'd1 || bus.crc_err !== 1'b0) begin
            failures++; $display("FAIL abort_restart: got lat=%0d nwr=%0d cnt=%0d crc=%b, expected 6 1 1 0",
                                 lat, wr_addr.size(), bus.byte_cnt_o, bus.crc_err);
        end
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) mem[i] = 8'h00;
        bus.start = 1'b0; bus.addr_in = 14'd0; bus.addr_out = 14'd0;
        test_reset();
        test_single();
        test_two(8'h1B, 1'b0);
        test_crc_err();
        test_hdr_err();
        test_wrap();
        test_busy_start();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/packet_deframer.md
PACKET_DEFRAMER -- requirements
Module: packet_deframer

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- SOF_MARK, 4'hC, required value of header byte 0 bits [7:4].

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, single clock; all state changes on rising edge.
- reset, in, 1, asynchronous, active-low reset.
- start, in, 1, request to parse one packet.
- addr_in, in, 14, byte address of header byte 0 in input memory.
- addr_out, in, 14, byte address where payload byte 0 is written in output memory.
- inmem_addr, out, 14, input memory read address.
- inmem_data_i, in, 32, input memory read data; bits [7:0] only; valid one cycle after inmem_addr.
- outmem_addr, out, 14, output memory write address.
- outmem_data_o, out, 32, write data: {24'h0, byte}.
- outmem_we, out, 1, write enable, one byte per cycle.
- busy, out, 1, high whenever state is not IDLE.
- irq, out, 1, one-cycle done pulse.
- crc_err, out, 1, CRC mismatch flag.
- hdr_err, out, 1, bad-header flag.
- byte_cnt_o, out, 5, number of payload bytes of the last packet (N+1).

Function
REQ-003 Packet layout SHALL be as follows, all offsets from addr_in:
- Byte 0: bits [7:4] = SOF_MARK; bits [3:0] = N.
- Byte 1: type; read and ignored.
- Bytes 2..N+2: payload, N+1 bytes.
- Byte N+3: CRC.

REQ-004 CRC SHALL be CRC-8 with polynomial 0x07 and init 0x00, MSB first, no reflection, no final XOR, computed over payload bytes only.

REQ-005 FSM states SHALL be IDLE, RD_HDR0, RD_HDR1, PAYLOAD, RD_CRC, CHK, DONE.

REQ-006 IDLE SHALL behave as follows:
- When start=1, latch addr_in, addr_out, clear crc_err/hdr_err/CRC register, and go to RD_HDR0.
- start while busy=1 SHALL be ignored.

REQ-007 RD_HDR0 SHALL drive inmem_addr=base, then go to RD_HDR1.

REQ-008 RD_HDR1 SHALL drive inmem_addr=base+1 and sample byte 0:
- If marker != SOF_MARK: set hdr_err=1, set byte_cnt_o=0, go to DONE.
- Otherwise: latch N, set byte_cnt_o=N+1, go to PAYLOAD.

REQ-009 PAYLOAD SHALL issue inmem_addr=base+2+i for i=0..N, one per cycle, then go to RD_CRC.

REQ-010 Each payload byte SHALL be written and folded into the CRC in the cycle after its address was issued:
- outmem_addr=addr_out+i, outmem_we=1, CRC register updated.
- This overlaps the following read; no bubbles.

REQ-011 RD_CRC SHALL drive inmem_addr=base+N+3; the last payload write occurs in this cycle; then go to CHK.

REQ-012 CHK SHALL compare inmem_data_i[7:0] with the final CRC, set crc_err=1 on mismatch, and go to DONE.

REQ-013 DONE SHALL assert irq for exactly one cycle and return to IDLE.

REQ-014 Latency: with start sampled at cycle 0, irq SHALL assert at cycle N+6 on success, and at cycle 3 on header error.

REQ-015 A header error SHALL produce no output writes, and crc_err SHALL remain 0.

REQ-016 All address arithmetic SHALL be 14-bit modulo 2^14; wrap past 14'h3FFF silently.

REQ-017 crc_err, hdr_err and byte_cnt_o SHALL hold until the next accepted start.

REQ-018 outmem_we SHALL be 0 in every cycle other than payload writes.

REQ-019 When inactive, inmem_addr, outmem_addr and outmem_data_o SHALL be 0.

Reset
REQ-020 When reset=0, the block SHALL asynchronously enter IDLE with:
- busy=0, irq=0, outmem_we=0, crc_err=0, hdr_err=0, byte_cnt_o=0;
- all address outputs=0;
- CRC and counter registers=0.

REQ-021 Reset mid-packet SHALL abort with no irq; bytes already written are not undone.

REQ-022 After reset release, the first start SHALL be accepted on the first rising edge with reset=1.

Verification
REQ-023 Single-byte packet: memory bytes C0,00,01,07 at addr_in=0x100, addr_out=0x200, start -> one write 0x01 to 0x200; irq at cycle 6; crc_err=0; byte_cnt_o=1.

REQ-024 Two-byte packet: bytes C1,55,01,02,1B -> writes 0x01@addr_out, 0x02@addr_out+1 on consecutive cycles; irq at cycle 7; crc_err=0; byte_cnt_o=2.

REQ-025 Same two-byte packet with CRC byte 0x1A -> both payload writes still performed; crc_err=1 with irq; flag held until next start.

REQ-026 Header byte 0 = 0xA3 -> hdr_err=1, irq at cycle 3, no outmem_we, byte_cnt_o=0.

REQ-027 Wrap: addr_in=0x3FFE, N=15, addr_out=0x3FF8 -> reads at 0x3FFE, 0x3FFF, 0x0000, ...; writes wrap to 0x0000 after 0x3FFF; 16 writes total; irq at cycle 21.

REQ-028 Reset and start robustness:
- Reset asserted during PAYLOAD -> outputs 0 immediately, no irq.
- start pulsed while busy -> ignored.
- Next start after reset release -> parses normally.
